// File: rtl/round_sequencer_if.sv
// Handshake/bus bundle for round_sequencer: start/abort control, round outputs,
// datapath feedback and the valid/ready result port.
interface round_sequencer_if #(
  parameter int DATA_W = 64,
  parameter int ROUNDS = 16
);
  localparam int CNT_W = $clog2(ROUNDS + 1);

  logic              start;
  logic              dir;
  logic              abort;
  logic [DATA_W-1:0] i_data;
  logic              busy;
  logic              round_en;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  key_idx;
  logic              first;
  logic              last;
  logic              o_valid;
  logic              o_ready;
  logic [DATA_W-1:0] o_data;

  modport master (
    output start, dir, abort, i_data, o_ready,
    input  busy, round_en, count, key_idx, first, last, o_valid, o_data
  );

  modport slave (
    input  start, dir, abort, i_data, o_ready,
    output busy, round_en, count, key_idx, first, last, o_valid, o_data
  );
endinterface

// File: rtl/round_sequencer.sv
// Round controller for iterative cipher datapaths: runs ROUNDS iterations per start,
// captures the last-round result and holds it under valid/ready back-pressure.
module round_sequencer #(
  parameter int DATA_W = 64,
  parameter int ROUNDS = 16
) (
  input  logic             clk,
  input  logic             reset,
  round_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(ROUNDS + 1);
  localparam logic [CNT_W-1:0] RND  = CNT_W'(ROUNDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  count_q;
  logic              dir_q;
  logic              o_valid_q;
  logic [DATA_W-1:0] o_data_q;
  logic              running;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count_q   <= RND;
      dir_q     <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // abort has no meaning here, so a coincident start still wins
          if (bus.start) begin
            state   <= RUN;
            count_q <= '0;
            dir_q   <= bus.dir;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state   <= IDLE;
            count_q <= RND;
          end else if (count_q == LAST) begin
            state     <= DONE;
            count_q   <= RND;
            o_data_q  <= bus.i_data;
            o_valid_q <= 1'b1;
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end
        DONE: begin
          // result is only released by a consumer handshake; a restart rides on that edge
          if (bus.o_ready) begin
            o_valid_q <= 1'b0;
            if (bus.start) begin
              state   <= RUN;
              count_q <= '0;
              dir_q   <= bus.dir;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          count_q <= RND;
        end
      endcase
    end
  end

  assign running      = (state == RUN);
  assign bus.busy     = running;
  assign bus.round_en = running;
  assign bus.count    = count_q;
  assign bus.key_idx  = running ? (dir_q ? LAST - count_q : count_q) : RND;
  assign bus.first    = running && (count_q == '0);
  assign bus.last     = running && (count_q == LAST);
  assign bus.o_valid  = o_valid_q;
  assign bus.o_data   = o_data_q;
endmodule

// File: tb/tb_round_sequencer.sv
// Drives a 16-round/64-bit and a 3-round/128-bit sequencer with shared control and
// checks both every cycle against a transaction-level model, plus literal spot checks.
module tb_round_sequencer;
  logic clk = 1'b0;
  logic reset, start, dir, abort, o_ready;
  logic [63:0]  i_data16;
  logic [127:0] i_data3;
  int errs = 0, checks = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  round_sequencer_if #(.DATA_W(64),  .ROUNDS(16)) b16 ();
  round_sequencer_if #(.DATA_W(128), .ROUNDS(3))  b3 ();

  assign b16.start = start;  assign b16.dir = dir;  assign b16.abort = abort;
  assign b16.o_ready = o_ready;  assign b16.i_data = i_data16;
  assign b3.start = start;   assign b3.dir = dir;   assign b3.abort = abort;
  assign b3.o_ready = o_ready;   assign b3.i_data = i_data3;

  round_sequencer #(.DATA_W(64),  .ROUNDS(16)) dut16 (.clk(clk), .reset(reset), .bus(b16));
  round_sequencer #(.DATA_W(128), .ROUNDS(3))  dut3  (.clk(clk), .reset(reset), .bus(b3));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: an operation is "running round k" or "holding result"
  int          rr[2] = '{16, 3};
  bit          m_run[2], m_hold[2], m_d[2];
  int          m_k[2];
  logic [127:0] m_res[2];

  always @(posedge clk) begin
    logic [127:0] din;
    for (int i = 0; i < 2; i++) begin
      din = (i == 0) ? {64'h0, i_data16} : i_data3;
      if (reset) begin
        m_run[i] = 0; m_hold[i] = 0; m_d[i] = 0; m_k[i] = 0; m_res[i] = '0;
      end else if (m_run[i]) begin
        if (abort) m_run[i] = 0;
        else if (m_k[i] == rr[i] - 1) begin
          m_run[i] = 0; m_hold[i] = 1; m_res[i] = din;
        end else m_k[i] = m_k[i] + 1;
      end else begin
        if (m_hold[i] && o_ready) m_hold[i] = 0;
        if (!m_hold[i] && start && !(m_hold[i])) begin
          // a held result blocks start unless released on this same edge
          m_run[i] = 1; m_k[i] = 0; m_d[i] = dir;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int ec, ek;
        string p;
        p  = (i == 0) ? "r16" : "r3";
        ec = m_run[i] ? m_k[i] : rr[i];
        ek = m_run[i] ? (m_d[i] ? rr[i] - 1 - m_k[i] : m_k[i]) : rr[i];
        if (i == 0) begin
          chk({p, ".busy"},     128'(b16.busy),     128'(m_run[i]));
          chk({p, ".round_en"}, 128'(b16.round_en), 128'(m_run[i]));
          chk({p, ".count"},    128'(b16.count),    128'(ec));
          chk({p, ".key_idx"},  128'(b16.key_idx),  128'(ek));
          chk({p, ".first"},    128'(b16.first),    128'(m_run[i] && m_k[i] == 0));
          chk({p, ".last"},     128'(b16.last),     128'(m_run[i] && m_k[i] == rr[i] - 1));
          chk({p, ".o_valid"},  128'(b16.o_valid),  128'(m_hold[i]));
          chk({p, ".o_data"},   128'(b16.o_data),   m_res[i]);
        end else begin
          chk({p, ".busy"},     128'(b3.busy),      128'(m_run[i]));
          chk({p, ".round_en"}, 128'(b3.round_en),  128'(m_run[i]));
          chk({p, ".count"},    128'(b3.count),     128'(ec));
          chk({p, ".key_idx"},  128'(b3.key_idx),   128'(ek));
          chk({p, ".first"},    128'(b3.first),     128'(m_run[i] && m_k[i] == 0));
          chk({p, ".last"},     128'(b3.last),      128'(m_run[i] && m_k[i] == rr[i] - 1));
          chk({p, ".o_valid"},  128'(b3.o_valid),   128'(m_hold[i]));
          chk({p, ".o_data"},   b3.o_data,          m_res[i]);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  localparam logic [63:0]  BASE16 = 64'hA5A5_0000_0000_0000;
  localparam logic [127:0] BASE3  = 128'hC3C3_0000_0000_0000_0000_0000_0000_0000;

  initial begin
    reset = 1; start = 0; dir = 0; abort = 0; o_ready = 0;
    i_data16 = '0; i_data3 = '0;
    cyc(); chk_en = 1; cyc();
    chk("rst.count16", 128'(b16.count), 128'd16);
    chk("rst.count3",  128'(b3.count),  128'd3);
    chk("rst.odata16", 128'(b16.o_data), 128'd0);
    reset = 0; cyc();

    // encrypt run, result held under o_ready low
    start = 1; dir = 0; cyc(); start = 0;
    for (int j = 0; j < 16; j++) begin
      chk("enc.key_idx16", 128'(b16.key_idx), 128'(j));
      chk("enc.first16",   128'(b16.first),   128'(j == 0));
      chk("enc.last16",    128'(b16.last),    128'(j == 15));
      i_data16 = BASE16 | 64'(j);
      i_data3  = BASE3  | 128'(j);
      cyc();
    end
    chk("enc.ovalid16", 128'(b16.o_valid), 128'd1);
    chk("enc.odata16",  128'(b16.o_data),  128'hA5A5_0000_0000_000F);
    chk("enc.odata3",   b3.o_data, 128'hC3C3_0000_0000_0000_0000_0000_0000_0002);

    start = 1;
    repeat (10) cyc();
    chk("hold.odata16", 128'(b16.o_data), 128'hA5A5_0000_0000_000F);
    chk("hold.busy16",  128'(b16.busy),   128'd0);

    // accept + restart on the same edge, decrypt with dir wiggling mid-run
    o_ready = 1; dir = 1; cyc(); start = 0; o_ready = 0;
    for (int j = 0; j < 16; j++) begin
      chk("dec.key_idx16", 128'(b16.key_idx), 128'(15 - j));
      dir = ~dir;
      cyc();
    end
    chk("dec.ovalid16", 128'(b16.o_valid), 128'd1);
    o_ready = 1; cyc();
    chk("drain.ovalid16", 128'(b16.o_valid), 128'd0);

    // abort on the last round, then mid-run
    start = 1; dir = 0; cyc(); start = 0;
    repeat (15) cyc();
    chk("ab15.count16", 128'(b16.count), 128'd15);
    abort = 1; cyc(); abort = 0;
    chk("ab15.ovalid16", 128'(b16.o_valid), 128'd0);
    chk("ab15.count16i", 128'(b16.count),   128'd16);
    start = 1; cyc(); start = 0;
    repeat (5) cyc();
    abort = 1; cyc(); abort = 0;
    chk("ab5.busy16", 128'(b16.busy), 128'd0);

    // reset mid-run
    start = 1; cyc(); start = 0;
    repeat (7) cyc();
    chk("rr.count16", 128'(b16.count), 128'd7);
    reset = 1; cyc(); reset = 0;
    chk("rr.busy16",   128'(b16.busy),   128'd0);
    chk("rr.count16i", 128'(b16.count),  128'd16);
    chk("rr.odata16",  128'(b16.o_data), 128'd0);

    for (int n = 0; n < 3000; n++) begin
      start    = ($urandom % 6) == 0;
      dir      = 1'($urandom);
      abort    = ($urandom % 25) == 0;
      o_ready  = 1'($urandom);
      reset    = ($urandom % 400) == 0;
      i_data16 = {$urandom, $urandom};
      i_data3  = {$urandom, $urandom, $urandom, $urandom};
      cyc();
    end
    reset = 0; start = 0; abort = 0;
    repeat (3) cyc();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
